// File: rtl/render_sequencer.sv
// Frame sequencer for a double-buffered 3D renderer. Once per frame it swaps
// the displayed buffer, latches the pose, clears the back buffer, starts the
// vertex fetch and waits for the rasterizer, counting frames that miss vblank.
module render_sequencer #(
  parameter int          H_ACTIVE = 1280,
  parameter int          V_ACTIVE = 720,
  parameter int          FB_DEPTH = 57600,
  parameter int          TIMEOUT  = 2000000,
  parameter logic [31:0] SCALE_FP = 32'h3F800000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [2:0]  btn_in,
  input  logic        obj_done_in,
  output logic        start_out,
  output logic        new_frame_out,
  output logic [15:0] clr_addr_out,
  output logic        clr_we_out,
  output logic        fb_sel_out,
  output logic [4:0]  pitch_out,
  output logic [4:0]  yaw_out,
  output logic [4:0]  roll_out,
  output logic [31:0] scale_out,
  output logic        busy_out,
  output logic [7:0]  drop_cnt_out
);

  localparam int               TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [15:0]      ADDR_LAST = 16'(FB_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RENDER  = 3'd2,
    WAIT_VB = 3'd3,
    SWAP    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      clr_addr_q, clr_addr_d;
  logic             clr_we_q, clr_we_d;
  logic             busy_q, busy_d;
  logic             pulse_q, pulse_d;
  logic             fb_sel_q, fb_sel_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [4:0]       pitch_q, pitch_d, yaw_q, yaw_d, roll_q, roll_d;
  logic [4:0]       pend_pitch_q, pend_pitch_d;
  logic [4:0]       pend_yaw_q, pend_yaw_d;
  logic [4:0]       pend_roll_q, pend_roll_d;
  logic [2:0]       btn_q;
  logic [2:0]       btn_rise;
  logic [7:0]       drop_q, drop_d;
  logic             drop_evt;
  logic             vblank_pulse;

  // A zero-width line never produces a pulse; otherwise one cycle at the
  // first pixel of the first blanking line.
  assign vblank_pulse = (vcount == 10'(V_ACTIVE)) && (hcount == 11'd0) && (H_ACTIVE > 0);

  // Next-state decode; every registered output is derived from the next state
  // so it lines up with the state register.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    tmo_d      = '0;
    fb_sel_d   = fb_sel_q;
    pitch_d    = pitch_q;
    yaw_d      = yaw_q;
    roll_d     = roll_q;
    drop_evt   = 1'b0;
    case (state_q)
      IDLE, WAIT_VB: begin
        if (vblank_pulse) state_d = SWAP;
      end
      SWAP: begin
        state_d    = CLEAR;
        fb_sel_d   = ~fb_sel_q;
        pitch_d    = pend_pitch_q;
        yaw_d      = pend_yaw_q;
        roll_d     = pend_roll_q;
        clr_addr_d = '0;
      end
      CLEAR: begin
        // A vblank here means the frame cannot make this swap.
        drop_evt = vblank_pulse;
        if (clr_addr_q == ADDR_LAST) begin
          state_d    = RENDER;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 16'd1;
        end
      end
      RENDER: begin
        drop_evt = vblank_pulse;
        tmo_d    = tmo_q + 1'b1;
        // The first RENDER cycle ignores obj_done so a stale flag from the
        // previous frame cannot end this one; done beats a same-cycle timeout.
        if ((tmo_q != '0) && obj_done_in) begin
          state_d = WAIT_VB;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = WAIT_VB;
          tmo_d    = '0;
          drop_evt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    clr_we_d = (state_d == CLEAR);
    busy_d   = (state_d == CLEAR) || (state_d == RENDER);
    pulse_d  = (state_q == CLEAR) && (state_d == RENDER);
  end

  // Pending pose and drop counter; the pending pose tracks buttons in every
  // state and is only exposed at SWAP.
  always_comb begin
    btn_rise     = btn_in & ~btn_q;
    pend_pitch_d = pend_pitch_q + 5'(btn_rise[0]);
    pend_yaw_d   = pend_yaw_q + 5'(btn_rise[1]);
    pend_roll_d  = pend_roll_q + 5'(btn_rise[2]);
    drop_d       = drop_q;
    if (drop_evt && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      clr_addr_q   <= '0;
      clr_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      pulse_q      <= 1'b0;
      fb_sel_q     <= 1'b0;
      tmo_q        <= '0;
      pitch_q      <= '0;
      yaw_q        <= '0;
      roll_q       <= '0;
      pend_pitch_q <= '0;
      pend_yaw_q   <= '0;
      pend_roll_q  <= '0;
      btn_q        <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_we_q     <= clr_we_d;
      busy_q       <= busy_d;
      pulse_q      <= pulse_d;
      fb_sel_q     <= fb_sel_d;
      tmo_q        <= tmo_d;
      pitch_q      <= pitch_d;
      yaw_q        <= yaw_d;
      roll_q       <= roll_d;
      pend_pitch_q <= pend_pitch_d;
      pend_yaw_q   <= pend_yaw_d;
      pend_roll_q  <= pend_roll_d;
      btn_q        <= btn_in;
      drop_q       <= drop_d;
    end
  end

  assign start_out     = pulse_q;
  assign new_frame_out = pulse_q;
  assign clr_addr_out  = clr_addr_q;
  assign clr_we_out    = clr_we_q;
  assign fb_sel_out    = fb_sel_q;
  assign pitch_out     = pitch_q;
  assign yaw_out       = yaw_q;
  assign roll_out      = roll_q;
  assign busy_out      = busy_q;
  assign drop_cnt_out  = drop_q;
  assign scale_out     = SCALE_FP;

endmodule

// File: tb/tb_render_sequencer.sv
// Scoreboard bench for render_sequencer: the stimulus queues the events it
// expects (frame start, busy fall, drop count change), the monitor observes
// them at the falling edge and compares in order.
module tb_render_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount = 11'd5;
  logic [9:0]  vcount = 10'd0;
  logic [2:0]  btn_in = 3'b000;
  logic        obj_done_in = 1'b0;
  logic        start_out, new_frame_out, clr_we_out, fb_sel_out, busy_out;
  logic [15:0] clr_addr_out;
  logic [4:0]  pitch_out, yaw_out, roll_out;
  logic [31:0] scale_out;
  logic [7:0]  drop_cnt_out;

  render_sequencer #(
    .H_ACTIVE(16), .V_ACTIVE(8), .FB_DEPTH(4), .TIMEOUT(20), .SCALE_FP(32'h3F800000)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount(hcount), .vcount(vcount),
    .btn_in(btn_in), .obj_done_in(obj_done_in), .start_out(start_out),
    .new_frame_out(new_frame_out), .clr_addr_out(clr_addr_out),
    .clr_we_out(clr_we_out), .fb_sel_out(fb_sel_out), .pitch_out(pitch_out),
    .yaw_out(yaw_out), .roll_out(roll_out), .scale_out(scale_out),
    .busy_out(busy_out), .drop_cnt_out(drop_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [1:0] EV_START = 2'd1, EV_DROP = 2'd2, EV_IDLE = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic        fb;
    logic [4:0]  p, y, r;
    logic [7:0]  drop;
    logic [7:0]  len;   // clear burst length for START, RENDER cycles for IDLE
    logic        nf, busy;
    logic [15:0] addr;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  function automatic ev_t mk_start(logic fb, logic [4:0] p, logic [4:0] y, logic [4:0] r, logic [7:0] d);
    ev_t e = '0;
    e.kind = EV_START; e.fb = fb; e.p = p; e.y = y; e.r = r; e.drop = d;
    e.len = 8'd4; e.nf = 1'b1; e.busy = 1'b1; e.addr = 16'd0;
    return e;
  endfunction

  function automatic ev_t mk_drop(logic [7:0] d);
    ev_t e = '0;
    e.kind = EV_DROP; e.drop = d;
    return e;
  endfunction

  function automatic ev_t mk_idle(logic [7:0] len, logic fb, logic [7:0] d);
    ev_t e = '0;
    e.kind = EV_IDLE; e.len = len; e.fb = fb; e.drop = d;
    return e;
  endfunction

  task automatic check_ev(input ev_t obs, input string name);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event got %h expected none", name, obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, obs, e);
      end
    end
  endtask

  // Monitor: reset values, then event extraction at the falling edge.
  logic [7:0] prev_drop = 8'd0;
  logic       prev_busy = 1'b0;
  logic       rst_seen  = 1'b0;
  int         burst_cnt = 0;
  logic       burst_ok  = 1'b1;
  int         rlen      = 0;

  always @(negedge clk_in) begin
    ev_t obs;
    if (!rst_in) begin
      if (!rst_seen) begin
        checks++;
        if ({start_out, new_frame_out, clr_we_out, busy_out, clr_addr_out, fb_sel_out,
             pitch_out, yaw_out, roll_out, drop_cnt_out} !== '0) begin
          errors++;
          $display("FAIL reset_outputs: got %h expected 0", {start_out, new_frame_out,
                   clr_we_out, busy_out, clr_addr_out, fb_sel_out, pitch_out, yaw_out,
                   roll_out, drop_cnt_out});
        end
        checks++;
        if (scale_out !== 32'h3F800000) begin
          errors++;
          $display("FAIL scale: got %h expected 3f800000", scale_out);
        end
      end
      rst_seen  = 1'b1;
      prev_drop = 8'd0;
      prev_busy = 1'b0;
      burst_cnt = 0;
      burst_ok  = 1'b1;
      rlen      = 0;
    end else begin
      rst_seen = 1'b0;
      if (clr_we_out) begin
        if (clr_addr_out != 16'(burst_cnt)) burst_ok = 1'b0;
        burst_cnt++;
      end
      if (drop_cnt_out !== prev_drop) begin
        obs = '0; obs.kind = EV_DROP; obs.drop = drop_cnt_out;
        check_ev(obs, "drop_change");
      end
      if (prev_busy && !busy_out) begin
        obs = '0; obs.kind = EV_IDLE; obs.len = 8'(rlen); obs.fb = fb_sel_out;
        obs.drop = drop_cnt_out;
        check_ev(obs, "frame_end");
      end
      if (start_out) begin
        obs = '0; obs.kind = EV_START; obs.fb = fb_sel_out; obs.p = pitch_out;
        obs.y = yaw_out; obs.r = roll_out; obs.drop = drop_cnt_out;
        obs.len = burst_ok ? 8'(burst_cnt) : 8'hFF; obs.nf = new_frame_out;
        obs.busy = busy_out; obs.addr = clr_addr_out;
        check_ev(obs, "frame_start");
        burst_cnt = 0;
        burst_ok  = 1'b1;
        rlen      = 1;
      end else if (busy_out && !clr_we_out) begin
        rlen++;
      end
      prev_drop = drop_cnt_out;
      prev_busy = busy_out;
    end
  end

  task automatic drive_raw(input logic [9:0] v, input logic [10:0] h, input logic od);
    vcount = v; hcount = h; obj_done_in = od;
    @(posedge clk_in); #1;
  endtask

  task automatic drive(input logic vb, input logic od);
    drive_raw(vb ? 10'd8 : 10'd0, vb ? 11'd0 : 11'd5, od);
  endtask

  // Tick 0 is the vblank that starts the frame; obj_done also pulses at
  // ticks 2 (CLEAR) and 6 (first RENDER cycle), where it must be ignored.
  task automatic frame(input int done_at, input logic [31:0] vb_mask, input int last,
                       input int btn_tick, input logic [2:0] btn_val);
    drive(1'b1, 1'b0);
    for (int i = 1; i <= last; i++) begin
      if (i == btn_tick) btn_in = btn_val;
      drive(vb_mask[i], (i == 2) || (i == 6) || (i == done_at));
    end
    drive_raw(10'd8, 11'd7, 1'b0);
    drive_raw(10'd3, 11'd0, 1'b1);
    repeat (3) drive(1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] md;
    logic       fb;
    #1 rst_in = 1'b0;
    repeat (3) drive(1'b0, 1'b0);
    rst_in = 1'b1;
    repeat (3) drive(1'b0, 1'b0);

    // First frame after reset, then a plain second frame.
    exp_q.push_back(mk_start(1'b1, 5'd0, 5'd0, 5'd0, 8'd0));
    exp_q.push_back(mk_idle(8'd5, 1'b1, 8'd0));
    frame(10, 32'h0, 10, -1, 3'b000);
    exp_q.push_back(mk_start(1'b0, 5'd0, 5'd0, 5'd0, 8'd0));
    exp_q.push_back(mk_idle(8'd5, 1'b0, 8'd0));
    frame(10, 32'h0, 10, -1, 3'b000);

    // Pitch held through three vblanks in RENDER: counts once, shows next frame.
    exp_q.push_back(mk_start(1'b1, 5'd0, 5'd0, 5'd0, 8'd0));
    exp_q.push_back(mk_drop(8'd1));
    exp_q.push_back(mk_drop(8'd2));
    exp_q.push_back(mk_drop(8'd3));
    exp_q.push_back(mk_idle(8'd15, 1'b1, 8'd3));
    frame(20, 32'h0001_1100, 20, 7, 3'b001);
    exp_q.push_back(mk_start(1'b0, 5'd1, 5'd0, 5'd0, 8'd3));
    exp_q.push_back(mk_idle(8'd5, 1'b0, 8'd3));
    frame(10, 32'h0, 10, -1, 3'b000);
    btn_in = 3'b000;
    drive(1'b0, 1'b0);

    // Simultaneous yaw+roll edge, then 31 pitch presses wrap pitch 1 -> 0.
    btn_in = 3'b110; drive(1'b0, 1'b0);
    btn_in = 3'b000; drive(1'b0, 1'b0);
    for (int k = 0; k < 31; k++) begin
      btn_in = 3'b001; drive(1'b0, 1'b0);
      btn_in = 3'b000; drive(1'b0, 1'b0);
    end
    // Roll edge in the SWAP cycle lands one frame later.
    exp_q.push_back(mk_start(1'b1, 5'd0, 5'd1, 5'd1, 8'd3));
    exp_q.push_back(mk_idle(8'd5, 1'b1, 8'd3));
    frame(10, 32'h0, 10, 1, 3'b100);
    btn_in = 3'b000;
    drive(1'b0, 1'b0);

    // Timeout abort; done on the 20th cycle; timeout with a same-cycle vblank.
    exp_q.push_back(mk_start(1'b0, 5'd0, 5'd1, 5'd2, 8'd3));
    exp_q.push_back(mk_drop(8'd4));
    exp_q.push_back(mk_idle(8'd20, 1'b0, 8'd4));
    frame(0, 32'h0, 26, -1, 3'b000);
    exp_q.push_back(mk_start(1'b1, 5'd0, 5'd1, 5'd2, 8'd4));
    exp_q.push_back(mk_idle(8'd20, 1'b1, 8'd4));
    frame(25, 32'h0, 25, -1, 3'b000);
    exp_q.push_back(mk_start(1'b0, 5'd0, 5'd1, 5'd2, 8'd4));
    exp_q.push_back(mk_drop(8'd5));
    exp_q.push_back(mk_idle(8'd20, 1'b0, 8'd5));
    frame(0, 32'h0200_0000, 26, -1, 3'b000);

    // Vblank during CLEAR: dropped, no extra toggle, swap at the next vblank.
    exp_q.push_back(mk_drop(8'd6));
    exp_q.push_back(mk_start(1'b1, 5'd0, 5'd1, 5'd2, 8'd6));
    exp_q.push_back(mk_idle(8'd5, 1'b1, 8'd6));
    frame(10, 32'h0000_0004, 10, -1, 3'b000);
    exp_q.push_back(mk_start(1'b0, 5'd0, 5'd1, 5'd2, 8'd6));
    exp_q.push_back(mk_idle(8'd5, 1'b0, 8'd6));
    frame(10, 32'h0, 10, -1, 3'b000);

    // Reset mid-RENDER: no start until the next vblank, which gives fb_sel=1.
    exp_q.push_back(mk_start(1'b1, 5'd0, 5'd1, 5'd2, 8'd6));
    drive(1'b1, 1'b0);
    repeat (9) drive(1'b0, 1'b0);
    rst_in = 1'b0;
    repeat (2) drive(1'b0, 1'b0);
    rst_in = 1'b1;
    repeat (30) drive(1'b0, 1'b0);
    exp_q.push_back(mk_start(1'b1, 5'd0, 5'd0, 5'd0, 8'd0));
    exp_q.push_back(mk_idle(8'd5, 1'b1, 8'd0));
    frame(10, 32'h0, 10, -1, 3'b000);

    // Vblank held through CLEAR and RENDER: 24 drops per frame, saturating.
    md = 8'd0;
    fb = 1'b1;
    for (int f = 0; f < 11; f++) begin
      fb = ~fb;
      for (int k = 0; k < 4; k++)
        if (md != 8'hFF) begin md++; exp_q.push_back(mk_drop(md)); end
      exp_q.push_back(mk_start(fb, 5'd0, 5'd0, 5'd0, md));
      for (int k = 0; k < 20; k++)
        if (md != 8'hFF) begin md++; exp_q.push_back(mk_drop(md)); end
      exp_q.push_back(mk_idle(8'd20, fb, md));
      frame(0, 32'h03FF_FFFC, 26, -1, 3'b000);
    end

    repeat (5) drive(1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/render_sequencer.md
RENDER_SEQUENCER -- requirements
Module: render_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 720: active lines; vblank starts at vcount==V_ACTIVE.
- FB_DEPTH, 57600: back-buffer words to clear (320x180).
- TIMEOUT, 2000000: max cycles in RENDER before abort.
- SCALE_FP, 32'h3F800000: IEEE-754 scale driven to the transformation stage.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_in, in, 1: pixel clock, the only clock.
- rst_in, in, 1: asynchronous, active-low reset.
- hcount, in, 11: video horizontal count.
- vcount, in, 10: video vertical count.
- btn_in, in, 3: pose buttons; [0] pitch, [1] yaw, [2] roll; already synchronized.
- obj_done_in, in, 1: rasterizer finished the last facet of the object.
- start_out, out, 1: one-cycle pulse that restarts vertex fetch.
- new_frame_out, out, 1: one-cycle pulse telling the rasterizer a frame begins.
- clr_addr_out, out, 16: back-buffer clear address.
- clr_we_out, out, 1: back-buffer clear write enable (data is 0).
- fb_sel_out, out, 1: buffer currently displayed; the rasterizer writes to the other one.
- pitch_out, out, 5: rotation index latched for the frame.
- yaw_out, out, 5: rotation index latched for the frame.
- roll_out, out, 5: rotation index latched for the frame.
- scale_out, out, 32: constant SCALE_FP.
- busy_out, out, 1: high in CLEAR or RENDER.
- drop_cnt_out, out, 8: saturating count of dropped frames.

Function
REQ-003 vblank_pulse SHALL be asserted for the single cycle where vcount==V_ACTIVE and hcount==0.
REQ-004 FSM states SHALL be IDLE, CLEAR, RENDER, WAIT_VB and SWAP.
REQ-005 IDLE SHALL go to SWAP on vblank_pulse.
REQ-006 SWAP SHALL last 1 cycle, invert fb_sel_out, copy the pending pose into pitch/yaw/roll_out, and then go to CLEAR.
REQ-007 CLEAR SHALL assert clr_we_out while clr_addr_out steps 0..FB_DEPTH-1, one address per cycle, taking exactly FB_DEPTH cycles.
REQ-008 After the CLEAR cycle with address FB_DEPTH-1, the FSM SHALL go to RENDER and clr_addr_out SHALL return to 0.
REQ-009 start_out and new_frame_out SHALL pulse together in the first RENDER cycle only.
REQ-010 RENDER SHALL go to WAIT_VB on obj_done_in==1, sampled from the second RENDER cycle onward; obj_done_in SHALL be ignored in every other state.
REQ-011 A RENDER cycle counter SHALL abort to WAIT_VB when it reaches TIMEOUT and SHALL increment drop_cnt_out.
REQ-012 WAIT_VB SHALL go to SWAP on vblank_pulse.
REQ-013 A vblank_pulse during CLEAR or RENDER SHALL NOT swap and SHALL NOT change state.
- drop_cnt_out SHALL increment (saturate at 255).
- The frame then completes and swaps on the next vblank.
REQ-014 Buttons:
- A rising edge of btn_in[i] (registered previous value) SHALL increment the pending index i by 1 mod 32 (31->0).
- Simultaneous edges SHALL each increment their own index.
- A held button SHALL count once.
REQ-015 The pending pose SHALL update in any state; outputs SHALL change only in SWAP, so the pose is stable for a whole frame.
REQ-016 A button edge in the SWAP cycle itself SHALL apply at the following SWAP.
REQ-017 If TIMEOUT and obj_done_in occur in the same cycle, obj_done_in SHALL win and there SHALL be no drop increment.
REQ-018 A timeout and a vblank drop in the same cycle SHALL increment drop_cnt_out by 1 only.
REQ-019 All outputs SHALL be registered; scale_out is the exception and is a constant.

Reset
REQ-020 rst_in==0 SHALL asynchronously force:
- state IDLE;
- start_out, new_frame_out, clr_we_out, busy_out = 0;
- clr_addr_out = 0; fb_sel_out = 0;
- pitch/yaw/roll_out and pending pose = 0;
- drop_cnt_out = 0; timeout counter = 0; button history = 0.
REQ-021 Reset asserted mid-CLEAR or mid-RENDER SHALL abandon the frame.
- After release, no start_out SHALL occur before the next vblank_pulse.
- The first vblank after release SHALL produce fb_sel_out=1.

Verification (FB_DEPTH=4, V_ACTIVE=8, H_ACTIVE=16, TIMEOUT=20)
REQ-022 Reset release, first vblank:
- Required: SWAP, fb_sel_out=1, then clr_we_out high for exactly 4 cycles with addr 0,1,2,3.
- Then start_out and new_frame_out pulse once; busy_out=1.
REQ-023 obj_done_in 5 cycles into RENDER -> WAIT_VB with busy_out=0; next vblank -> fb_sel_out=0, drop_cnt_out=0.
REQ-024 btn_in=3'b001 held for 3 vblanks during RENDER -> pitch_out=1 only at the next SWAP; yaw_out and roll_out stay 0.
- 32 separate presses -> pitch wraps back to 0.
REQ-025 obj_done_in never asserted -> abort after 20 RENDER cycles, drop_cnt_out=1; obj_done_in on cycle 20 -> drop_cnt_out stays 0.
REQ-026 vblank forced during CLEAR -> no fb_sel_out toggle, drop_cnt_out=1, swap at the following vblank.
- rst_in pulsed low mid-RENDER -> all outputs 0 immediately.
